// File: rtl/me_unit_pkg.sv
// me_unit_pkg: shared widths, bus field positions and rdata state encoding
// for the memory-access (ME) pipeline stage.
package me_unit_pkg;

  localparam int unsigned EX_BUS_W = 71;
  localparam int unsigned WB_BUS_W = 70;
  localparam int unsigned FWD_W    = 37;
  localparam int unsigned DEST_W   = 5;
  localparam int unsigned WORD_W   = 32;

  // EX_to_ME_Bus = {pc, alu_result, res_from_mem, gr_we, dest}
  localparam int unsigned EX_PC_LSB  = 39;
  localparam int unsigned EX_ALU_LSB = 7;
  localparam int unsigned EX_RFM_BIT = 6;
  localparam int unsigned EX_WE_BIT  = 5;

  // ME_to_WB_Bus = {pc, final_result, gr_we, dest}
  localparam int unsigned WB_PC_LSB  = 38;
  localparam int unsigned WB_RES_LSB = 6;
  localparam int unsigned WB_WE_BIT  = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } me_state_e;

endpackage

// File: rtl/me_unit_if.sv
// me_unit_if: EX->ME handshake, data SRAM read data, ME->WB handshake and
// the hazard/forwarding buses of the ME stage.
//   slave  : the ME stage itself
//   master : the surrounding pipeline (EX, SRAM, WB, hazard unit)
interface me_unit_if;
  import me_unit_pkg::*;

  logic                EX_to_ME_Valid;
  logic [EX_BUS_W-1:0] EX_to_ME_Bus;
  logic                ME_Allow_in;
  logic [WORD_W-1:0]   data_sram_rdata;
  logic                ME_to_WB_Valid;
  logic                WB_Allow_in;
  logic [WB_BUS_W-1:0] ME_to_WB_Bus;
  logic [DEST_W-1:0]   ME_dest;
  logic [FWD_W-1:0]    ME_Forward;

  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward
  );

  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward
  );

endinterface

// File: rtl/me_rdata_hold.sv
// me_rdata_hold: tracks whether the instruction in ME is in its first cycle
// (SRAM read data live) or stalled (read data captured in a hold register),
// and selects the read-data source accordingly.
// Ports:
//   clk, resetn       clock, async active-low reset
//   i_entry           an instruction is captured into ME on this edge
//   i_wb_allow_in     WB accepts the current instruction this cycle
//   i_rdata           data_sram_rdata
//   o_rdata_source    read data belonging to the instruction in ME
module me_rdata_hold
  import me_unit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_entry,
  input  logic              i_wb_allow_in,
  input  logic [WORD_W-1:0] i_rdata,
  output logic [WORD_W-1:0] o_rdata_source
);

  me_state_e         r_state;
  me_state_e         w_next;
  logic              w_hold_we;
  logic [WORD_W-1:0] r_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hold_we) r_hold <= i_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_hold_we = 1'b0;
    case (r_state)
      ST_EMPTY: if (i_entry) w_next = ST_FRESH;
      ST_FRESH: begin
        if (i_wb_allow_in) begin
          w_next = i_entry ? ST_FRESH : ST_EMPTY;
        end else begin
          // SRAM data is only live this one cycle; capture it as we stall.
          w_next    = ST_HELD;
          w_hold_we = 1'b1;
        end
      end
      ST_HELD: if (i_wb_allow_in) w_next = i_entry ? ST_FRESH : ST_EMPTY;
      default: w_next = ST_EMPTY;
    endcase
  end

  assign o_rdata_source = (r_state == ST_HELD) ? r_hold : i_rdata;

endmodule

// File: rtl/me_unit.sv
// me_unit: memory-access stage of the 5-stage LoongArch pipeline.
// Captures the EX payload, pairs it with the SRAM read data (buffered across
// WB stalls) and forms the writeback result and forwarding buses.
// Ports:
//   clk, resetn   clock, async active-low reset
//   me_if         slave side of me_unit_if (EX/SRAM/WB handshakes, hazard buses)
module me_unit
  import me_unit_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  me_unit_if.slave   me_if
);

  logic              r_valid;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_alu;
  logic              r_rfm;
  logic              r_we;
  logic [DEST_W-1:0] r_dest;

  logic              w_allow_in;
  logic              w_entry;
  logic [WORD_W-1:0] w_rdata_src;
  logic [WORD_W-1:0] w_final;
  logic [DEST_W-1:0] w_me_dest;

  // ReadyGo is constant 1, so ME only blocks while WB is blocking.
  assign w_allow_in = !r_valid || me_if.WB_Allow_in;
  assign w_entry    = w_allow_in && me_if.EX_to_ME_Valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_alu   <= '0;
      r_rfm   <= 1'b0;
      r_we    <= 1'b0;
      r_dest  <= '0;
    end else begin
      if (w_allow_in) r_valid <= me_if.EX_to_ME_Valid;
      if (w_entry) begin
        r_pc   <= me_if.EX_to_ME_Bus[EX_PC_LSB +: WORD_W];
        r_alu  <= me_if.EX_to_ME_Bus[EX_ALU_LSB +: WORD_W];
        r_rfm  <= me_if.EX_to_ME_Bus[EX_RFM_BIT];
        r_we   <= me_if.EX_to_ME_Bus[EX_WE_BIT];
        r_dest <= me_if.EX_to_ME_Bus[DEST_W-1:0];
      end
    end
  end

  me_rdata_hold u_rdata_hold (
    .clk            (clk),
    .resetn         (resetn),
    .i_entry        (w_entry),
    .i_wb_allow_in  (me_if.WB_Allow_in),
    .i_rdata        (me_if.data_sram_rdata),
    .o_rdata_source (w_rdata_src)
  );

  assign w_final   = r_rfm ? w_rdata_src : r_alu;
  assign w_me_dest = r_dest & {DEST_W{r_valid}};

  assign me_if.ME_Allow_in    = w_allow_in;
  assign me_if.ME_to_WB_Valid = r_valid;
  assign me_if.ME_to_WB_Bus   = {r_pc, w_final, r_we, r_dest};
  assign me_if.ME_dest        = w_me_dest;
  assign me_if.ME_Forward     = {w_me_dest, w_final};

endmodule
